// File: rtl/mmio_bus_arbiter.sv
// Two-master round-robin arbiter for the shared 16-bit MMIO bus.
// Each transaction is IDLE -> ISSUE -> [WAIT x RD_LAT] -> RESP, with one
// strobe in ISSUE and a one-cycle done pulse to the owner in RESP.
// Every output is a flop. The comb block computes next values, so the
// ISSUE-cycle strobe is already registered on entry to ISSUE.
module mmio_bus_arbiter #(
    parameter int AW     = 16,
    parameter int DW     = 16,
    parameter int RD_LAT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m0_we,
    input  logic          m0_re,
    output logic          m0_gnt,
    output logic          m0_done,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic          m1_we,
    input  logic          m1_re,
    output logic          m1_gnt,
    output logic          m1_done,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    output logic          bus_we,
    output logic          bus_re,
    input  logic [DW-1:0] bus_rdata
);

    localparam int CW = 4;  // holds RD_LAT up to 15

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic [1:0] {OP_NOP, OP_WR, OP_RD} op_t;

    state_t        state, state_n;
    op_t           op, op_n;
    logic          owner, owner_n;
    logic          rr, rr_n;
    logic [CW-1:0] cnt, cnt_n;

    logic          m0_gnt_n, m1_gnt_n, m0_done_n, m1_done_n;
    logic [DW-1:0] m0_rdata_n, m1_rdata_n;
    logic [AW-1:0] bus_addr_n;
    logic [DW-1:0] bus_wdata_n;
    logic          bus_we_n, bus_re_n;

    logic          sel, sel_we, sel_re, finish;

    // Next state and next registered outputs; finish marks the read-sample/complete cycle.
    always_comb begin
        state_n     = state;
        op_n        = op;
        owner_n     = owner;
        rr_n        = rr;
        cnt_n       = cnt;
        m0_gnt_n    = m0_gnt;
        m1_gnt_n    = m1_gnt;
        m0_done_n   = 1'b0;
        m1_done_n   = 1'b0;
        m0_rdata_n  = m0_rdata;
        m1_rdata_n  = m1_rdata;
        bus_addr_n  = bus_addr;
        bus_wdata_n = bus_wdata;
        bus_we_n    = 1'b0;
        bus_re_n    = 1'b0;
        sel         = 1'b0;
        sel_we      = 1'b0;
        sel_re      = 1'b0;
        finish      = 1'b0;

        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    // a lone requester wins outright; a tie goes to the RR pointer
                    sel         = (m0_req && m1_req) ? rr : m1_req;
                    sel_we      = sel ? m1_we : m0_we;
                    sel_re      = sel ? m1_re : m0_re;
                    op_n        = sel_we ? OP_WR : (sel_re ? OP_RD : OP_NOP);
                    owner_n     = sel;
                    bus_addr_n  = sel ? m1_addr : m0_addr;
                    bus_wdata_n = sel ? m1_wdata : m0_wdata;
                    bus_we_n    = sel_we;
                    bus_re_n    = !sel_we && sel_re;
                    m0_gnt_n    = !sel;
                    m1_gnt_n    = sel;
                    state_n     = ISSUE;
                end
            end
            ISSUE: begin
                if (op == OP_RD && RD_LAT != 0) begin
                    cnt_n   = CW'(RD_LAT);
                    state_n = WAIT;
                end else begin
                    finish = 1'b1;
                end
            end
            WAIT: begin
                cnt_n = cnt - CW'(1);
                if (cnt == CW'(1)) finish = 1'b1;
            end
            RESP: begin
                m0_gnt_n = 1'b0;
                m1_gnt_n = 1'b0;
                rr_n     = !owner;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (finish) begin
            state_n     = RESP;
            bus_addr_n  = '0;
            bus_wdata_n = '0;
            m0_done_n   = !owner;
            m1_done_n   = owner;
            if (op == OP_RD) begin
                if (owner) m1_rdata_n = bus_rdata;
                else       m0_rdata_n = bus_rdata;
            end
        end
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op        <= OP_NOP;
            owner     <= 1'b0;
            rr        <= 1'b0;
            cnt       <= '0;
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_done   <= 1'b0;
            m1_done   <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_we    <= 1'b0;
            bus_re    <= 1'b0;
        end else begin
            state     <= state_n;
            op        <= op_n;
            owner     <= owner_n;
            rr        <= rr_n;
            cnt       <= cnt_n;
            m0_gnt    <= m0_gnt_n;
            m1_gnt    <= m1_gnt_n;
            m0_done   <= m0_done_n;
            m1_done   <= m1_done_n;
            m0_rdata  <= m0_rdata_n;
            m1_rdata  <= m1_rdata_n;
            bus_addr  <= bus_addr_n;
            bus_wdata <= bus_wdata_n;
            bus_we    <= bus_we_n;
            bus_re    <= bus_re_n;
        end
    end

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Bench for mmio_bus_arbiter: three instances with RD_LAT = 0, 3, 4, each
// with a peripheral that returns valid data only exactly RD_LAT cycles after
// bus_re. A per-transaction timeline model predicts every output each cycle.
module tb_mmio_bus_arbiter;

    localparam logic [15:0] DEAD = 16'hDEAD;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0]       m0_req, m0_we, m0_re, m1_req, m1_we, m1_re;
    logic [2:0][15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [2:0]       m0_gnt, m1_gnt, m0_done, m1_done, bus_we, bus_re;
    logic [2:0][15:0] m0_rdata, m1_rdata, bus_addr, bus_wdata, bus_rdata;

    int n_chk = 0;
    int n_fail = 0;

    function automatic logic [15:0] periph(input logic [15:0] a);
        case (a)
            16'hC001: return 16'h0155;
            16'h0010: return 16'h1234;
            default:  return a ^ 16'h5A5A;
        endcase
    endfunction

    function automatic int lat_of(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 3 : 4);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = (g == 0) ? 0 : ((g == 1) ? 3 : 4);
        mmio_bus_arbiter #(.AW(16), .DW(16), .RD_LAT(L)) u_dut (
            .clk(clk), .rst(rst),
            .m0_req(m0_req[g]), .m0_addr(m0_addr[g]), .m0_wdata(m0_wdata[g]),
            .m0_we(m0_we[g]), .m0_re(m0_re[g]), .m0_gnt(m0_gnt[g]),
            .m0_done(m0_done[g]), .m0_rdata(m0_rdata[g]),
            .m1_req(m1_req[g]), .m1_addr(m1_addr[g]), .m1_wdata(m1_wdata[g]),
            .m1_we(m1_we[g]), .m1_re(m1_re[g]), .m1_gnt(m1_gnt[g]),
            .m1_done(m1_done[g]), .m1_rdata(m1_rdata[g]),
            .bus_addr(bus_addr[g]), .bus_wdata(bus_wdata[g]),
            .bus_we(bus_we[g]), .bus_re(bus_re[g]), .bus_rdata(bus_rdata[g])
        );
        if (L == 0) begin : g_comb
            assign bus_rdata[g] = bus_re[g] ? periph(bus_addr[g]) : DEAD;
        end else begin : g_dly
            logic        rh [16] = '{default: 1'b0};
            logic [15:0] ah [16] = '{default: 16'h0};
            always @(posedge clk) begin
                for (int k = 15; k > 0; k--) begin
                    rh[k] <= rh[k-1];
                    ah[k] <= ah[k-1];
                end
                rh[0] <= bus_re[g];
                ah[0] <= bus_addr[g];
            end
            assign bus_rdata[g] = rh[L-1] ? periph(ah[L-1]) : DEAD;
        end
    end

    // Model: a transaction is a timeline k = 1..tot after the grant cycle,
    // tot = 2 + (read ? RD_LAT : 0). Strobe at k=1, done at k=tot,
    // address on the bus for k < tot.
    logic        mbusy [3], mown [3], mrr [3];
    int          mk [3], mtot [3], mop [3];
    logic [15:0] mad [3], mwd [3], merd0 [3], merd1 [3];

    function automatic logic msel(input int i);
        return (m0_req[i] && m1_req[i]) ? mrr[i] : m1_req[i];
    endfunction

    function automatic int mopc(input int i);
        logic s, w, r;
        s = msel(i);
        w = s ? m1_we[i] : m0_we[i];
        r = s ? m1_re[i] : m0_re[i];
        return w ? 1 : (r ? 2 : 0);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                mbusy[i] <= 1'b0;
                mrr[i]   <= 1'b0;
                merd0[i] <= 16'h0;
                merd1[i] <= 16'h0;
            end else if (mbusy[i]) begin
                if (mk[i] == mtot[i]) begin
                    mbusy[i] <= 1'b0;
                    mrr[i]   <= ~mown[i];
                end else begin
                    mk[i] <= mk[i] + 1;
                    if (mk[i] + 1 == mtot[i] && mop[i] == 2) begin
                        if (mown[i]) merd1[i] <= periph(mad[i]);
                        else         merd0[i] <= periph(mad[i]);
                    end
                end
            end else if (m0_req[i] || m1_req[i]) begin
                mbusy[i] <= 1'b1;
                mown[i]  <= msel(i);
                mop[i]   <= mopc(i);
                mad[i]   <= msel(i) ? m1_addr[i] : m0_addr[i];
                mwd[i]   <= msel(i) ? m1_wdata[i] : m0_wdata[i];
                mk[i]    <= 1;
                mtot[i]  <= 2 + ((mopc(i) == 2) ? lat_of(i) : 0);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic check_all();
        logic [69:0] e, a;
        logic b, t;
        for (int i = 0; i < 3; i++) begin
            b = mbusy[i];
            t = b && (mk[i] == mtot[i]);
            e = {b && !mown[i], b && mown[i], t && !mown[i], t && mown[i],
                 b && mk[i] == 1 && mop[i] == 1, b && mk[i] == 1 && mop[i] == 2,
                 (b && mk[i] < mtot[i]) ? mad[i] : 16'h0,
                 (b && mk[i] < mtot[i]) ? mwd[i] : 16'h0,
                 merd0[i], merd1[i]};
            a = {m0_gnt[i], m1_gnt[i], m0_done[i], m1_done[i], bus_we[i], bus_re[i],
                 bus_addr[i], bus_wdata[i], m0_rdata[i], m1_rdata[i]};
            n_chk++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL model inst%0d t=%0t: got %h, want %h", i, $time, a, e);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_all();
    endtask

    // Drive one transaction, hold req until done, then drop it and idle one cycle.
    task automatic run_txn(input int i, input logic m, input logic [15:0] a, input logic [15:0] wd,
                           input logic we, input logic re, output int lat, output int nwe,
                           output int nre, output logic [15:0] sa, output logic [15:0] swd);
        logic dn;
        if (m) begin
            m1_req[i] = 1'b1; m1_addr[i] = a; m1_wdata[i] = wd; m1_we[i] = we; m1_re[i] = re;
        end else begin
            m0_req[i] = 1'b1; m0_addr[i] = a; m0_wdata[i] = wd; m0_we[i] = we; m0_re[i] = re;
        end
        lat = 0; nwe = 0; nre = 0; sa = 16'h0; swd = 16'h0; dn = 1'b0;
        while (!dn && lat < 40) begin
            tick();
            lat++;
            if (bus_we[i] || bus_re[i]) begin sa = bus_addr[i]; swd = bus_wdata[i]; end
            if (bus_we[i]) nwe++;
            if (bus_re[i]) nre++;
            dn = m ? m1_done[i] : m0_done[i];
        end
        m0_req[i] = 1'b0;
        m1_req[i] = 1'b0;
        if (!dn) begin
            n_chk++; n_fail++;
            $display("FAIL txn_timeout inst%0d m%0d: no done within %0d cycles", i, m, lat);
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, nwe, nre, ov;
        logic [15:0] sa, swd;
        int order[$];

        rst = 1'b1;
        m0_req = '0; m0_we = '0; m0_re = '0; m1_req = '0; m1_we = '0; m1_re = '0;
        m0_addr = '0; m0_wdata = '0; m1_addr = '0; m1_wdata = '0;
        tick(); tick();
        chk("reset_ctrl", 32'({m0_gnt, m1_gnt, m0_done, m1_done, bus_we, bus_re}), 32'h0);
        chk("reset_addr", 32'(bus_addr[0]), 32'h0);
        rst = 1'b0;

        // m0 write to LED register, combinational-read instance
        run_txn(0, 1'b0, 16'hC000, 16'h02AA, 1'b1, 1'b0, lat, nwe, nre, sa, swd);
        chk("wr_latency", 32'(lat), 32'd2);
        chk("wr_we_pulses", 32'(nwe), 32'd1);
        chk("wr_re_pulses", 32'(nre), 32'd0);
        chk("wr_bus_addr", 32'(sa), 32'h0000C000);
        chk("wr_bus_wdata", 32'(swd), 32'h000002AA);

        // m1 read of switches, same-cycle data
        run_txn(0, 1'b1, 16'hC001, 16'h0, 1'b0, 1'b1, lat, nwe, nre, sa, swd);
        chk("rd0_latency", 32'(lat), 32'd2);
        chk("rd0_re_pulses", 32'(nre), 32'd1);
        chk("rd0_m1_rdata", 32'(m1_rdata[0]), 32'h00000155);
        chk("rd0_m0_rdata", 32'(m0_rdata[0]), 32'h0);

        // RD_LAT=3 read: data present only 3 cycles after the strobe
        run_txn(1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b1, lat, nwe, nre, sa, swd);
        chk("rd3_latency", 32'(lat), 32'd5);
        chk("rd3_strobes", 32'(nwe + nre), 32'd1);
        chk("rd3_m0_rdata", 32'(m0_rdata[1]), 32'h00001234);

        rst = 1'b1;
        tick(); tick();
        chk("reset_rdata", 32'(m0_rdata[1]), 32'h0);
        rst = 1'b0;

        // both masters requesting continuously from reset
        m0_req[0] = 1'b1; m0_addr[0] = 16'hC000; m0_wdata[0] = 16'h0001; m0_we[0] = 1'b1; m0_re[0] = 1'b0;
        m1_req[0] = 1'b1; m1_addr[0] = 16'hC002; m1_wdata[0] = 16'h0002; m1_we[0] = 1'b1; m1_re[0] = 1'b0;
        ov = 0;
        for (int c = 0; c < 40 && order.size() < 6; c++) begin
            tick();
            if (m0_done[0] && m1_done[0]) ov++;
            if (m0_done[0]) order.push_back(0);
            if (m1_done[0]) order.push_back(1);
        end
        m0_req[0] = 1'b0; m1_req[0] = 1'b0;
        tick();
        chk("rr_count", 32'(order.size()), 32'd6);
        chk("rr_overlap", 32'(ov), 32'd0);
        for (int j = 0; j < 6 && j < order.size(); j++)
            chk($sformatf("rr_order%0d", j), 32'(order[j]), 32'(j % 2));

        // reset during WAIT of an RD_LAT=4 read aborts it
        m0_req[2] = 1'b1; m0_addr[2] = 16'h0020; m0_we[2] = 1'b0; m0_re[2] = 1'b1;
        tick(); tick(); tick();
        chk("abort_in_wait", 32'({m0_gnt[2], bus_re[2], bus_addr[2]}), 32'h00020020);
        rst = 1'b1;
        tick();
        chk("abort_ctrl", 32'({m0_gnt[2], m1_gnt[2], m0_done[2], m1_done[2], bus_we[2], bus_re[2]}), 32'h0);
        chk("abort_addr", 32'(bus_addr[2]), 32'h0);
        rst = 1'b0;
        m0_req[2] = 1'b0;
        ov = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (m0_done[2]) ov++;
        end
        chk("abort_no_done", 32'(ov), 32'd0);
        run_txn(2, 1'b1, 16'hC001, 16'h0, 1'b0, 1'b1, lat, nwe, nre, sa, swd);
        chk("rd4_latency", 32'(lat), 32'd6);
        chk("rd4_m1_rdata", 32'(m1_rdata[2]), 32'h00000155);

        // boundary ops
        run_txn(0, 1'b1, 16'hC000, 16'h00FF, 1'b1, 1'b1, lat, nwe, nre, sa, swd);
        chk("wr_wins_we", 32'(nwe), 32'd1);
        chk("wr_wins_re", 32'(nre), 32'd0);
        run_txn(0, 1'b0, 16'hC001, 16'h0, 1'b0, 1'b0, lat, nwe, nre, sa, swd);
        chk("nop_latency", 32'(lat), 32'd2);
        chk("nop_strobes", 32'(nwe + nre), 32'd0);
        run_txn(1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, lat, nwe, nre, sa, swd);
        chk("nop_lat3_latency", 32'(lat), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
